// File: rtl/bnn_host_link.sv
// Host-side stream master for the BNN accelerator: feeds IN_WORDS input words,
// collects 2-bit results, packs eight per 16-bit word into a small result FIFO.
module bnn_host_link #(
  parameter int IN_WORDS   = 49,
  parameter int RES_COUNT  = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode_sel,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [15:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_overflow,
  output logic        mode_o,
  output logic [15:0] data_in_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  input  logic [1:0]  data_out_i,
  input  logic        out_en_i
);
  localparam int ICW = $clog2(IN_WORDS + 1);
  localparam int RCW = $clog2(RES_COUNT + 1);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [ICW-1:0] IN_N     = ICW'(IN_WORDS);
  localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_WORDS - 1);
  localparam logic [RCW-1:0] RES_N    = RCW'(RES_COUNT);
  localparam logic [RCW-1:0] RES_LAST = RCW'(RES_COUNT - 1);
  localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [ICW-1:0]              in_cnt;
  logic [RCW-1:0]              res_cnt;
  logic [TW-1:0]               timer;
  logic [15:0]                 pack, merged;
  logic [FIFO_DEPTH-1:0][15:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic [2:0]                  slot;
  logic xfer, accept, cap, timeout_hit, push, push_ok, pop, full, empty;

  assign xfer   = in_valid_o & in_ready_i;
  // words already handed over plus the one held on the pins must not exceed the frame
  assign src_ready = (state == LOAD) && (ICW'(in_cnt + ICW'(in_valid_o)) < IN_N) &&
                     (!in_valid_o || in_ready_i);
  assign accept = src_valid & src_ready;

  assign slot   = 3'(res_cnt);
  assign cap    = (state == LOAD || state == WAIT) && out_en_i && (res_cnt < RES_N);
  assign timeout_hit = (state == WAIT) && (res_cnt != RES_N) && (timer == T_LAST);
  assign merged = cap ? (pack | (16'(data_out_i) << {slot, 1'b0})) : pack;
  // a partial word exists whenever the slot index is off a word boundary
  assign push   = (cap && (slot == 3'd7 || res_cnt == RES_LAST)) ||
                  (timeout_hit && (cap || slot != 3'd0));

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign res_valid = !empty;
  assign res_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = res_valid & res_ready;
  assign push_ok   = push && (!full || pop);

  assign busy = (state == LOAD) || (state == WAIT);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (xfer && in_cnt == IN_LAST) state_nxt = WAIT;
      WAIT:    if (res_cnt == RES_N || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_cnt       <= '0;
      res_cnt      <= '0;
      timer        <= '0;
      pack         <= '0;
      mode_o       <= 1'b0;
      data_in_o    <= '0;
      in_valid_o   <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mem          <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        mode_o       <= mode_sel;
        in_cnt       <= '0;
        res_cnt      <= '0;
        timer        <= '0;
        err_timeout  <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (xfer) in_cnt <= in_cnt + ICW'(1);
      if (state == LOAD) begin
        if (accept) begin
          data_in_o  <= src_data;
          in_valid_o <= 1'b1;
        end else if (in_ready_i) begin
          in_valid_o <= 1'b0;
        end
      end else begin
        in_valid_o <= 1'b0;
      end
      if (cap) res_cnt <= res_cnt + RCW'(1);
      pack <= push ? 16'h0000 : merged;
      if (state == WAIT) timer <= timer + TW'(1);
      if (timeout_hit) err_timeout <= 1'b1;
      if (push && full && !pop) err_overflow <= 1'b1;
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= merged;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: tb/tb_bnn_host_link.sv
// Randomized bench for bnn_host_link: host source, accelerator responder and
// result drain driven per cycle; packed words checked against a list-based model.
module tb_bnn_host_link;
  localparam int IN_WORDS = 49, RES_COUNT = 10, FIFO_DEPTH = 4, TIMEOUT = 4096;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode_sel = 1'b0;
  logic [15:0] src_data = '0;
  logic src_valid = 1'b0, src_ready;
  logic [15:0] res_data;
  logic res_valid, res_ready = 1'b0;
  logic busy, done, err_timeout, err_overflow, mode_o;
  logic [15:0] data_in_o;
  logic in_valid_o, in_ready_i = 1'b0;
  logic [1:0] data_out_i = '0;
  logic out_en_i = 1'b0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bnn_host_link #(.IN_WORDS(IN_WORDS), .RES_COUNT(RES_COUNT),
                  .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_overflow(err_overflow),
    .mode_o(mode_o), .data_in_o(data_in_o), .in_valid_o(in_valid_o),
    .in_ready_i(in_ready_i), .data_out_i(data_out_i), .out_en_i(out_en_i)
  );

  logic [15:0] src_words[$];
  logic [15:0] xfers[$];
  logic [1:0]  res_q[$];
  logic [15:0] got[$];
  logic [15:0] exp_w[$];
  int src_idx, done_cnt, wait_cyc, stall_err;
  bit ready_off, ready_duty, src_rand, res_rand, res_early, drain_en, drain_rand, start_spam;
  bit start_req, prev_hold;
  logic start_mode;
  logic [15:0] prev_data;

  // Expected packed words: results beyond RES_COUNT ignored, eight per word,
  // last word closed at RES_COUNT; flush adds a trailing partial word.
  function automatic void model_pack(input logic [1:0] v[$], input bit flush);
    logic [15:0] cur = '0;
    int n = (v.size() < RES_COUNT) ? v.size() : RES_COUNT;
    for (int k = 0; k < n; k++) begin
      cur |= 16'(v[k]) << (2 * (k % 8));
      if (k % 8 == 7 || k == RES_COUNT - 1) begin
        exp_w.push_back(cur);
        cur = '0;
      end
    end
    if (flush && n % 8 != 0 && n < RES_COUNT) exp_w.push_back(cur);
  endfunction

  function automatic int word_diffs();
    int d = (got.size() != exp_w.size()) ? 1 : 0;
    foreach (exp_w[i]) if (i < got.size()) if (got[i] !== exp_w[i]) d++;
    return d;
  endfunction

  function automatic int xfer_diffs();
    int d = (xfers.size() != src_words.size()) ? 1 : 0;
    foreach (src_words[i]) if (i < xfers.size()) if (xfers[i] !== src_words[i]) d++;
    return d;
  endfunction

  // one clock of all three partners; inputs change on the falling edge
  task automatic drive_cycle();
    @(negedge clk);
    start    = start_req || start_spam;
    mode_sel = start_req ? start_mode : !start_mode;
    start_req = 1'b0;
    in_ready_i = ready_off ? 1'b0 : (ready_duty ? ($urandom_range(0, 2) == 0) : 1'b1);
    if (src_idx < src_words.size() && (!src_rand || $urandom_range(0, 1) == 1)) begin
      src_valid = 1'b1;
      src_data  = src_words[src_idx];
    end else begin
      src_valid = 1'b0;
      src_data  = 16'($urandom);
    end
    if (busy && res_q.size() > 0 && (res_early || xfers.size() >= IN_WORDS) &&
        (!res_rand || $urandom_range(0, 1) == 1)) begin
      out_en_i   = 1'b1;
      data_out_i = res_q.pop_front();
    end else begin
      out_en_i   = 1'b0;
      data_out_i = 2'($urandom);
    end
    res_ready = drain_en && (!drain_rand || $urandom_range(0, 1) == 1);
    #1;
    if (busy && xfers.size() >= IN_WORDS) wait_cyc++;
    if (prev_hold && !(in_valid_o && data_in_o == prev_data)) stall_err++;
    prev_hold = in_valid_o && !in_ready_i;
    prev_data = data_in_o;
    if (src_valid && src_ready) src_idx++;
    if (in_valid_o && in_ready_i) xfers.push_back(data_in_o);
    if (res_valid && res_ready) got.push_back(res_data);
    if (done) begin
      done_cnt++;
      start_spam = 1'b0;
    end
  endtask

  task automatic begin_frame(input logic m);
    src_idx = 0; xfers.delete(); done_cnt = 0; wait_cyc = 0; stall_err = 0; prev_hold = 1'b0;
    start_req = 1'b1; start_mode = m;
    drive_cycle();
    drive_cycle();
  endtask

  task automatic finish_frame(input int budget, output bit ok);
    int n = 0;
    while (n < budget && done_cnt == 0) begin
      drive_cycle();
      n++;
    end
    ok = (done_cnt != 0);
    repeat (3) drive_cycle();
  endtask

  task automatic drain(input int n);
    drain_en = 1'b1; drain_rand = 1'b0;
    repeat (n) drive_cycle();
  endtask

  task automatic test_reset();
    logic [49:0] outs;
    repeat (2) @(negedge clk);
    #1 outs = {src_ready, res_valid, res_data, busy, done, err_timeout, err_overflow,
               mode_o, data_in_o, in_valid_o};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_init outputs got %h expected 0", outs); end
    rst_n = 1'b1;
    ready_off = 1'b1;
    src_words.delete();
    for (int i = 0; i < 8; i++) src_words.push_back(16'($urandom) | 16'h0001);
    begin_frame(1'b1);
    repeat (3) drive_cycle();
    checks++;
    if ({in_valid_o, busy, mode_o} !== 3'b111) begin
      errors++; $display("FAIL reset_pre in_valid/busy/mode got %b expected 111", {in_valid_o, busy, mode_o});
    end
    @(negedge clk);
    rst_n = 1'b0; in_ready_i = 1'b1; src_valid = 1'b1; out_en_i = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_en_i = 1'b0;
    #1 outs = {src_ready, res_valid, res_data, busy, done, err_timeout, err_overflow,
               mode_o, data_in_o, in_valid_o};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_mid outputs got %h expected 0", outs); end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, in_valid_o, res_valid, src_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_idle busy/in_valid/res_valid/src_ready got %b expected 0000",
                         {busy, in_valid_o, res_valid, src_ready});
    end
    ready_off = 1'b0;
  endtask

  task automatic test_nominal();
    logic [1:0] vals[$] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    bit ok;
    src_words.delete();
    for (int i = 0; i < IN_WORDS; i++) src_words.push_back(16'(i));
    ready_duty = 0; src_rand = 0; res_rand = 0; res_early = 0; drain_en = 0;
    res_q = vals; got.delete(); exp_w.delete(); model_pack(vals, 1'b0);
    begin_frame(1'b1);
    finish_frame(500, ok);
    drain(6);
    checks++; if (!ok) begin errors++; $display("FAIL nominal_done no done within budget"); end
    checks++; if (xfers.size() != IN_WORDS) begin errors++; $display("FAIL nominal_xfer_count got %0d expected %0d", xfers.size(), IN_WORDS); end
    checks++; if (xfer_diffs() != 0) begin errors++; $display("FAIL nominal_xfer_data %0d differences", xfer_diffs()); end
    checks++; if (word_diffs() != 0) begin errors++; $display("FAIL nominal_words got %0d words expected %0d", got.size(), exp_w.size()); end
    checks++;
    if (got.size() != 2 || got[0] !== 16'hE4E4 || got[1] !== 16'h0009) begin
      errors++; $display("FAIL nominal_values got %0d words expected E4E4,0009", got.size());
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL nominal_done_pulses got %0d expected 1", done_cnt); end
    checks++; if (mode_o !== 1'b1) begin errors++; $display("FAIL nominal_mode got %b expected 1", mode_o); end
    checks++; if ({err_timeout, err_overflow} !== 2'b00) begin errors++; $display("FAIL nominal_errs got %b expected 00", {err_timeout, err_overflow}); end
  endtask

  task automatic test_backpressure();
    logic [1:0] vals[$];
    bit ok;
    for (int it = 0; it < 3; it++) begin
      src_words.delete(); vals.delete();
      for (int i = 0; i < IN_WORDS; i++) src_words.push_back(16'($urandom));
      for (int i = 0; i < RES_COUNT; i++) vals.push_back(2'($urandom));
      ready_duty = 1; src_rand = 1; res_rand = 1; res_early = bit'(it == 2);
      drain_en = 1; drain_rand = 1;
      res_q = vals; got.delete(); exp_w.delete(); model_pack(vals, 1'b0);
      begin_frame(1'(it));
      finish_frame(3000, ok);
      drain(8);
      checks++; if (!ok) begin errors++; $display("FAIL bp_done iter %0d no done within budget", it); end
      checks++; if (xfers.size() != IN_WORDS || xfer_diffs() != 0) begin
        errors++; $display("FAIL bp_xfers iter %0d got %0d transfers (%0d diffs) expected %0d", it, xfers.size(), xfer_diffs(), IN_WORDS);
      end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable iter %0d got %0d unstable cycles expected 0", it, stall_err); end
      checks++; if (word_diffs() != 0) begin errors++; $display("FAIL bp_words iter %0d got %0d words expected %0d", it, got.size(), exp_w.size()); end
      checks++; if (mode_o !== 1'(it)) begin errors++; $display("FAIL bp_mode iter %0d got %b expected %b", it, mode_o, 1'(it)); end
    end
    ready_duty = 0; src_rand = 0; res_rand = 0; res_early = 0;
  endtask

  task automatic test_overflow();
    logic [1:0] vals[$];
    bit ok;
    got.delete(); exp_w.delete();
    src_words.delete();
    for (int i = 0; i < IN_WORDS; i++) src_words.push_back(16'($urandom));
    for (int f = 0; f < 4; f++) begin
      vals.delete();
      for (int i = 0; i < RES_COUNT; i++) vals.push_back(2'($urandom));
      res_q = vals;
      if (f != 2) model_pack(vals, 1'b0);
      drain_en = 0;
      begin_frame(1'b0);
      if (f == 3) begin
        checks++; if ({busy, err_overflow} !== 2'b10) begin
          errors++; $display("FAIL ovf_clear busy/err_overflow got %b expected 10", {busy, err_overflow});
        end
        drain_en = 1; drain_rand = 0;
      end
      finish_frame(500, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_done frame %0d no done within budget", f); end
      if (f == 1) begin
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b expected 0", err_overflow); end
      end
      if (f == 2) begin
        checks++; if ({err_overflow, res_valid} !== 2'b11) begin
          errors++; $display("FAIL ovf_set err_overflow/res_valid got %b expected 11", {err_overflow, res_valid});
        end
      end
    end
    drain(8);
    checks++; if (word_diffs() != 0 || got.size() != FIFO_DEPTH + 2) begin
      errors++; $display("FAIL ovf_words got %0d words (%0d diffs) expected %0d", got.size(), word_diffs(), FIFO_DEPTH + 2);
    end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_final got %b expected 0", err_overflow); end
  endtask

  task automatic test_timeout();
    logic [1:0] vals[$];
    bit ok;
    for (int i = 0; i < 3; i++) vals.push_back(2'($urandom_range(1, 3)));
    res_q = vals; got.delete(); exp_w.delete(); model_pack(vals, 1'b1);
    drain_en = 1; drain_rand = 0;
    begin_frame(1'b1);
    finish_frame(TIMEOUT + 500, ok);
    drain(4);
    checks++; if (!ok) begin errors++; $display("FAIL to_done no done within budget"); end
    checks++; if (wait_cyc != TIMEOUT) begin errors++; $display("FAIL to_wait_cycles got %0d expected %0d", wait_cyc, TIMEOUT); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b expected 1", err_timeout); end
    checks++; if (word_diffs() != 0 || got.size() != 1) begin
      errors++; $display("FAIL to_word got %0d words (first %h) expected 1 (%h)", got.size(), got.size() > 0 ? got[0] : 16'h0, exp_w[0]);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL to_done_pulses got %0d expected 1", done_cnt); end
  endtask

  task automatic test_early_extras();
    logic [1:0] vals[$];
    bit ok;
    for (int i = 0; i < RES_COUNT + 2; i++) vals.push_back(2'($urandom));
    src_words.delete();
    for (int i = 0; i < IN_WORDS; i++) src_words.push_back(16'($urandom));
    res_q = vals; got.delete(); exp_w.delete(); model_pack(vals, 1'b0);
    res_early = 1; res_rand = 1; drain_en = 1; drain_rand = 0;
    begin_frame(1'b0);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL early_to_clear got %b expected 0", err_timeout); end
    start_spam = 1'b1;
    finish_frame(800, ok);
    drain(4);
    checks++; if (!ok) begin errors++; $display("FAIL early_done no done within budget"); end
    checks++; if (word_diffs() != 0 || got.size() != 2) begin
      errors++; $display("FAIL early_words got %0d words (%0d diffs) expected 2", got.size(), word_diffs());
    end
    checks++; if (mode_o !== 1'b0) begin errors++; $display("FAIL early_mode got %b expected 0", mode_o); end
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL early_restart done_cnt %0d busy %b expected 1 and 0", done_cnt, busy);
    end
    res_early = 0; res_rand = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_early_extras();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bnn_host_link.md
Name: bnn_host_link

Overview:
- Host-side master for the BNN accelerator's chip-level stream interface.
- Drives the accelerator input pins: mode, 16-bit data_in, in_valid. Obeys in_ready.
- Collects the 2-bit results the accelerator returns on data_out, qualified by out_en.
- Packs eight results per 16-bit word into a small result FIFO for the host/FPGA fabric. Runs one inference frame per start pulse.

Parameters:
- IN_WORDS, 49, number of 16-bit input words per frame.
- RES_COUNT, 10, number of 2-bit results expected per frame.
- FIFO_DEPTH, 4, result FIFO depth in 16-bit words (power of 2).
- TIMEOUT, 4096, maximum cycles spent in WAIT before aborting.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a frame; honoured only in IDLE.
- mode_sel  in  1  mode value for the frame; latched on start.
- src_data  in  16  input word from host.
- src_valid  in  1  src_data valid.
- src_ready  out  1  src word accepted when src_valid & src_ready.
- res_data  out  16  packed result word; result k of the word is at bits [2k+1:2k].
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  pop when res_valid & res_ready.
- busy  out  1  high in LOAD and WAIT.
- done  out  1  one-cycle pulse on frame completion.
- err_timeout  out  1  sticky; cleared by start.
- err_overflow  out  1  sticky; cleared by start.
- mode_o  out  1  to accelerator mode pin.
- data_in_o  out  16  to accelerator data_in.
- in_valid_o  out  1  to accelerator in_valid.
- in_ready_i  in  1  from accelerator in_ready.
- data_out_i  in  2  from accelerator data_out.
- out_en_i  in  1  from accelerator out_en; qualifies data_out_i.

Behaviour:
- Reset, on the rising edge with rst_n=0:
  - All outputs go to 0; res_data reads 0.
  - State is IDLE; all counters, the pack register and the FIFO are cleared.
  - Applies mid-frame: in_valid_o drops on the next edge and no handshake completes.
- States: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - start=1 latches mode_sel into mode_o and clears in_cnt, res_cnt, timer, err_timeout and err_overflow. Next state is LOAD.
  - start is ignored in every other state.
  - mode_o holds its value until the next accepted start.
- LOAD, input side:
  - in_valid_o and data_in_o are registered outputs.
  - src_ready = (sent+pending < IN_WORDS) & (!in_valid_o | in_ready_i).
  - On src accept, data_in_o <= src_data and in_valid_o <= 1 (1-cycle latency).
  - While in_valid_o & !in_ready_i, data_in_o and in_valid_o hold stable.
  - A transfer is in_valid_o & in_ready_i on an edge; each transfer increments in_cnt.
  - in_valid_o drops after the final transfer unless a new word is loaded.
  - When in_cnt reaches IN_WORDS, next state is WAIT.
- Result capture, in LOAD and WAIT only; out_en_i is ignored in IDLE and DONE:
  - Each cycle with out_en_i=1 and res_cnt < RES_COUNT writes data_out_i into slot res_cnt%8 of the pack word, then res_cnt increments.
  - out_en_i pulses beyond RES_COUNT are ignored.
- Packing and FIFO push:
  - The word is pushed on the same edge its slot 7 fills, or on the edge of the final result (res_cnt = RES_COUNT-1).
  - The pushed word is the pack register merged combinationally with the incoming pair; unused upper slots are 0. The pack register then clears.
  - Result latency: out_en_i at cycle t completing a word gives res_valid=1 at t+1.
- FIFO:
  - res_valid = !empty; res_data = head entry.
  - Drains in all states, including while busy.
  - A push when full with no pop on the same edge drops the word and sets err_overflow.
  - Push and pop on the same edge when full are both accepted.
- WAIT:
  - timer increments each cycle.
  - All RES_COUNT results captured → DONE.
  - timer reaching TIMEOUT-1 sets err_timeout, pushes any non-empty partial pack word, then → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE. busy=0 in IDLE and DONE.
- Simultaneous events:
  - The final input transfer and an out_en_i can occur on the same edge; both are processed.
  - A start asserted on the DONE cycle is ignored.

Test Plan:
- Reset: hold rst_n=0 for 2 edges mid-LOAD with in_valid_o=1 → next cycle all outputs 0, state IDLE, res_valid=0.
- Nominal frame: IN_WORDS=49, src words 0x0000..0x0030 with in_ready_i always 1, then 10 out_en_i pulses carrying values 0,1,2,3,0,1,2,3,1,2 →
  - data_in_o shows the words in order, exactly 49 transfers.
  - res_data word 0 = 0xE4E4, word 1 = 0x0009.
  - done pulses once and mode_o equals the latched mode_sel.
- Backpressure: toggle in_ready_i at 1/3 duty and src_valid randomly → data_in_o stable whenever in_valid_o & !in_ready_i; no word lost or duplicated; transfer count = 49.
- Overflow: FIFO_DEPTH=4, res_ready=0, RES_COUNT=40 → first 4 words stored, 5th dropped, err_overflow=1. It clears on the next start.
- Timeout: TIMEOUT=16, only 3 results supplied → err_timeout=1 at the 16th WAIT cycle; one word with low 6 bits populated and the rest 0; done pulses.
- Early results and extras: results arrive during LOAD plus 2 extra out_en_i pulses after RES_COUNT → extras ignored, exactly 2 words pushed; start during busy ignored.
